// File: rtl/user_pkg.sv
// User-domain shared definitions: manager count and manager index map.
// The user subordinate address map is defined elsewhere and is not touched here.
package user_pkg;

   // Number of OBI managers living in the user domain.
   localparam int unsigned NumUserDomainManagers = 1;

   // Manager index of each user-domain manager on the crossbar.
   typedef enum int unsigned {
      UserDma = 0
   } user_manager_idx_e;

   // Byte enable used for full 32-bit word accesses.
   localparam logic [3:0] DmaBeFull = 4'hF;

endpackage

// File: rtl/user_dma_mgr.sv
// User DMA manager: copies len_i 32-bit words from src_addr_i to dst_addr_i
// over a single OBI manager port, one transaction outstanding at a time,
// strictly alternating read then write for each word.
module user_dma_mgr
   import user_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned LenWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // control
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] src_addr_i,
   input  logic [AddrWidth-1:0] dst_addr_i,
   input  logic [LenWidth-1:0]  len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   // OBI manager
   output logic                 req_o,
   input  logic                 gnt_i,
   output logic [AddrWidth-1:0] addr_o,
   output logic                 we_o,
   output logic [3:0]           be_o,
   output logic [DataWidth-1:0] wdata_o,
   input  logic                 rvalid_i,
   input  logic [DataWidth-1:0] rdata_i,
   input  logic                 err_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_RSP,
      WR_REQ,
      WR_RSP,
      DONE
   } state_e;

   localparam logic [AddrWidth-1:0] WordStep = AddrWidth'(4);
   localparam logic [LenWidth-1:0]  LastWord = LenWidth'(1);

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] src_q, src_d;
   logic [AddrWidth-1:0] dst_q, dst_d;
   logic [LenWidth-1:0]  cnt_q, cnt_d;
   logic [DataWidth-1:0] buf_q, buf_d;
   logic                 err_q, err_d;

   // State and datapath registers; reset clears everything so stale
   // transfer context can never leak into the next launch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others, independent of statement order.
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   // Next-state and OBI output decode; the bus is driven only in request
   // states and is all-zero otherwise.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      err_d   = err_q;
      req_o   = 1'b0;
      we_o    = 1'b0;
      be_o    = 4'h0;
      addr_o  = '0;
      wdata_o = '0;
      done_o  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               src_d   = {src_addr_i[AddrWidth-1:2], 2'b00};
               dst_d   = {dst_addr_i[AddrWidth-1:2], 2'b00};
               cnt_d   = len_i;
               err_d   = 1'b0;
               state_d = (len_i == '0) ? DONE : RD_REQ;
            end
         end

         RD_REQ: begin
            req_o  = 1'b1;
            be_o   = DmaBeFull;
            addr_o = src_q;
            if (gnt_i) state_d = RD_RSP;
         end

         RD_RSP: begin
            if (rvalid_i) begin
               if (err_i) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  buf_d   = rdata_i;
                  state_d = WR_REQ;
               end
            end
         end

         WR_REQ: begin
            req_o   = 1'b1;
            we_o    = 1'b1;
            be_o    = DmaBeFull;
            addr_o  = dst_q;
            wdata_o = buf_q;
            if (gnt_i) state_d = WR_RSP;
         end

         WR_RSP: begin
            if (rvalid_i) begin
               if (err_i) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  src_d   = src_q + WordStep;
                  dst_d   = dst_q + WordStep;
                  cnt_d   = cnt_q - LastWord;
                  state_d = (cnt_q == LastWord) ? DONE : RD_REQ;
               end
            end
         end

         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy_o  = (state_q != IDLE);
   assign error_o = err_q;

endmodule

// File: tb/tb_user_dma_mgr.sv
// Self-checking bench for user_dma_mgr: an OBI subordinate model answers
// every granted transaction one cycle later, and a scoreboard queue holds
// the expected bus operations in issue order.
module tb_user_dma_mgr;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [31:0] src_addr_i;
   logic [31:0] dst_addr_i;
   logic [15:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic        req_o;
   logic        gnt_i;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        err_i;

   user_dma_mgr #(
      .AddrWidth (32),
      .DataWidth (32),
      .LenWidth  (16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o),
      .req_o      (req_o),
      .gnt_i      (gnt_i),
      .addr_o     (addr_o),
      .we_o       (we_o),
      .be_o       (be_o),
      .wdata_o    (wdata_o),
      .rvalid_i   (rvalid_i),
      .rdata_i    (rdata_i),
      .err_i      (err_i)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // subordinate-model state
   logic        pend_v      = 1'b0;
   logic        pend_we     = 1'b0;
   logic [31:0] pend_addr   = '0;
   logic        hold_wr_rsp = 1'b0;
   int          rd_seen     = 0;
   int          err_rd_idx  = 0;
   int          stall_left  = 0;
   logic        stall_on    = 1'b0;
   int          done_cnt    = 0;
   int          wr_cnt      = 0;
   int          req_cnt     = 0;
   int          idle_bus_bad    = 0;
   int          outstanding_bad = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Contents of source memory: a fixed scramble of the word address.
   function automatic logic [31:0] src_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // OBI subordinate: outputs are sampled and inputs driven on the falling edge.
   initial begin
      txn_t e;
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      rdata_i  = '0;
      err_i    = 1'b0;
      forever begin
         @(negedge clk_i);
         if (pend_v && req_o) outstanding_bad++;
         if (!req_o && (addr_o != 0 || wdata_o != 0 || we_o || be_o != 0)) idle_bus_bad++;
         // response phase for the transaction granted last cycle
         rvalid_i = 1'b0;
         err_i    = 1'b0;
         rdata_i  = '0;
         if (pend_v && !(pend_we && hold_wr_rsp)) begin
            rvalid_i = 1'b1;
            if (!pend_we) begin
               rd_seen++;
               rdata_i = src_word(pend_addr);
               if (rd_seen == err_rd_idx) err_i = 1'b1;
            end
            pend_v = 1'b0;
         end
         // request phase
         gnt_i = 1'b1;
         if (stall_left > 0 && (stall_on || (req_o && we_o))) begin
            stall_on = 1'b1;
            gnt_i    = 1'b0;
            stall_left--;
            check("bp_req_held", req_o, 1'b1);
            check("bp_we_held", we_o, 1'b1);
            if (exp_q.size() > 0) begin
               check("bp_addr_stable", addr_o, exp_q[0].addr);
               check("bp_wdata_stable", wdata_o, exp_q[0].data);
            end
         end
         if (req_o) req_cnt++;
         if (done_o) done_cnt++;
         if (req_o && gnt_i) begin
            if (exp_q.size() == 0) begin
               check("req_with_empty_queue", req_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("op_we", we_o, e.we);
               check("op_addr", addr_o, e.addr);
               check("op_be", be_o, 4'hF);
               if (e.we) check("op_wdata", wdata_o, e.data);
            end
            pend_v    = 1'b1;
            pend_we   = we_o;
            pend_addr = addr_o;
            if (we_o) wr_cnt++;
         end
      end
   end

   // Push the expected R,W,R,W... sequence, then pulse start for one cycle.
   task automatic launch(input logic [31:0] src, input logic [31:0] dst,
                         input int len, input int err_rd);
      txn_t        e;
      logic [31:0] sa;
      logic [31:0] da;
      sa = {src[31:2], 2'b00};
      da = {dst[31:2], 2'b00};
      for (int i = 0; i < len; i++) begin
         e.we   = 1'b0;
         e.addr = sa + 32'(4 * i);
         e.data = '0;
         exp_q.push_back(e);
         if (i + 1 == err_rd) break;
         e.we   = 1'b1;
         e.addr = da + 32'(4 * i);
         e.data = src_word(sa + 32'(4 * i));
         exp_q.push_back(e);
      end
      done_cnt   = 0;
      wr_cnt     = 0;
      rd_seen    = 0;
      req_cnt    = 0;
      err_rd_idx = err_rd;
      start_i    = 1'b1;
      src_addr_i = src;
      dst_addr_i = dst;
      len_i      = 16'(len);
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   // Observe from the first cycle after start until done_o, bounded by budget.
   task automatic wait_done(input int budget, output int done_lat,
                            output int req_to_done, output int busy_cyc);
      int first_req;
      logic seen;
      first_req   = -1;
      seen        = 1'b0;
      busy_cyc    = 0;
      done_lat    = -1;
      req_to_done = -1;
      for (int c = 1; c <= budget; c++) begin
         if (busy_o) busy_cyc++;
         if (req_o && first_req < 0) first_req = c;
         if (done_o) begin
            seen        = 1'b1;
            done_lat    = c;
            req_to_done = (first_req < 0) ? 0 : c - first_req;
            break;
         end
         @(negedge clk_i);
      end
      check("done_seen", seen, 1'b1);
      @(negedge clk_i);
      check("done_one_cycle", done_o, 1'b0);
      check("idle_after_done", busy_o, 1'b0);
   endtask

   initial begin
      int lat, r2d, bc, bad;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      src_addr_i = '0;
      dst_addr_i = '0;
      len_i      = '0;
      #1;
      check("rst_req", req_o, 1'b0);
      check("rst_we", we_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_error", error_o, 1'b0);
      check("rst_addr", addr_o, 32'h0);
      check("rst_wdata", wdata_o, 32'h0);
      check("rst_be", be_o, 4'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // copy: 3 words, gnt tied high, response one cycle after grant
      launch(32'h2000_0000, 32'h1000_0100, 3, 0);
      wait_done(100, lat, r2d, bc);
      check("copy_req_to_done", r2d, 12);
      check("copy_done_pulses", done_cnt, 1);
      check("copy_writes", wr_cnt, 3);
      check("copy_queue_empty", exp_q.size(), 0);
      check("copy_error", error_o, 1'b0);

      // backpressure: first write held off for 5 cycles
      stall_on   = 1'b0;
      stall_left = 5;
      launch(32'h2000_0040, 32'h1000_0200, 2, 0);
      wait_done(100, lat, r2d, bc);
      check("bp_stall_consumed", stall_left, 0);
      check("bp_req_to_done", r2d, 8 + 5);
      check("bp_queue_empty", exp_q.size(), 0);
      stall_on = 1'b0;

      // zero length: no bus activity, done one cycle after start
      launch(32'h2000_0000, 32'h1000_0000, 0, 0);
      wait_done(20, lat, r2d, bc);
      check("zero_done_lat", lat, 1);
      check("zero_busy_cycles", bc, 1);
      check("zero_no_req", req_cnt, 0);

      // bus error on the second read of four
      launch(32'h2000_1000, 32'h1000_1000, 4, 2);
      wait_done(100, lat, r2d, bc);
      check("err_flag", error_o, 1'b1);
      check("err_writes", wr_cnt, 1);
      check("err_done_pulses", done_cnt, 1);
      check("err_queue_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk_i);
      check("err_sticky", error_o, 1'b1);
      launch(32'h2000_0000, 32'h1000_0000, 0, 0);
      check("err_cleared_on_start", error_o, 1'b0);
      wait_done(20, lat, r2d, bc);

      // reset while waiting for the first write response
      hold_wr_rsp = 1'b1;
      launch(32'h4000_0000, 32'h5000_0000, 2, 0);
      for (int c = 0; c < 50 && wr_cnt == 0; c++) @(negedge clk_i);
      @(negedge clk_i);
      check("pre_rst_in_wr_rsp", {busy_o, req_o}, 2'b10);
      #2 rst_i = 1'b1;
      #1;
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_req", req_o, 1'b0);
      check("mid_rst_addr", addr_o, 32'h0);
      check("mid_rst_wdata", wdata_o, 32'h0);
      check("mid_rst_we_be", {we_o, be_o}, 5'h0);
      check("mid_rst_done_err", {done_o, error_o}, 2'b00);
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      hold_wr_rsp = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         if (busy_o || req_o || done_o || error_o) bad++;
      end
      check("stray_rvalid_ignored", bad, 0);

      // wrap and alignment: misaligned source rolls over the top of memory
      launch(32'hFFFF_FFFF, 32'h3000_0000, 2, 0);
      wait_done(100, lat, r2d, bc);
      check("wrap_writes", wr_cnt, 2);
      check("wrap_queue_empty", exp_q.size(), 0);

      check("bus_zero_when_idle", idle_bus_bad, 0);
      check("single_outstanding", outstanding_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/user_dma_mgr.md
USER_DMA_MGR -- requirements
Module: user_dma_mgr

Interface
REQ-001 Parameters SHALL be: AddrWidth, default 32, OBI address width; DataWidth, default 32, OBI data width; LenWidth, default 16, transfer length counter width in words.
REQ-002 Port clk_i SHALL be an input, 1 bit wide, and serve as the single clock; all state updates on its rising edge.
REQ-003 Port rst_i SHALL be an input, 1 bit wide, and act as the reset: asynchronous, active-high.
REQ-004 Port start_i SHALL be an input, 1 bit wide, and act as a one-cycle launch pulse; it is sampled only in IDLE.
REQ-005 Ports src_addr_i and dst_addr_i SHALL be inputs, AddrWidth wide, holding the source and destination byte addresses; both are captured on start.
REQ-006 Port len_i SHALL be an input, LenWidth wide, giving the number of 32-bit words to copy; it is captured on start.
REQ-007 Port busy_o SHALL be an output, 1 bit wide, high in every state other than IDLE.
REQ-008 Port done_o SHALL be an output, 1 bit wide, giving a one-cycle completion pulse.
REQ-009 Port error_o SHALL be an output, 1 bit wide, acting as a sticky bus-error flag.
REQ-010 OBI manager ports SHALL be: req_o (out, 1), gnt_i (in, 1), addr_o (out, AddrWidth), we_o (out, 1), be_o (out, 4), wdata_o (out, DataWidth), rvalid_i (in, 1), rdata_i (in, DataWidth), err_i (in, 1).

Function
REQ-011 The FSM SHALL have the states IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP and DONE.
REQ-012 In IDLE, start_i=1 with len_i=0 SHALL go to DONE; start_i=1 with len_i>0 SHALL go to RD_REQ.
REQ-013 On start, the block SHALL capture src/dst with bits [1:0] forced to 0, load the remaining count with len_i, and clear error_o.
REQ-014 RD_REQ SHALL drive req_o=1, we_o=0, be_o=4'hF and addr_o=current source address; on gnt_i=1 it SHALL go to RD_RSP.
REQ-015 RD_RSP SHALL drive req_o=0; on rvalid_i=1 with err_i=0 it SHALL latch rdata_i into the data buffer and go to WR_REQ.
REQ-016 WR_REQ SHALL drive req_o=1, we_o=1, be_o=4'hF, addr_o=current destination address and wdata_o=buffer; on gnt_i it SHALL go to WR_RSP.
REQ-017 On rvalid_i in WR_RSP, the block SHALL add 4 to both addresses (wrapping modulo 2^AddrWidth) and decrement the count; if the count was 1 it SHALL go to DONE, else to RD_REQ.
REQ-018 While req_o=1 and gnt_i=0, the block SHALL hold addr_o, we_o, be_o and wdata_o stable; req_o SHALL NOT drop before grant.
REQ-019 The block SHALL keep at most one transaction outstanding; it SHALL NOT assert req_o while waiting for rvalid_i.
REQ-020 rvalid_i=1 with err_i=1 in RD_RSP or WR_RSP SHALL set error_o and go to DONE, abandoning the remaining words.
REQ-021 gnt_i and rvalid_i arriving in the same cycle SHALL be treated as the grant then, in the following cycle, the response is expected; the subordinate returns rvalid_i no earlier than one cycle after gnt_i.
REQ-022 rvalid_i received outside the RD_RSP/WR_RSP states SHALL be ignored.
REQ-023 DONE SHALL assert done_o for exactly one cycle, then go to IDLE; error_o SHALL stay set until the next start.
REQ-024 Minimum per-word latency SHALL be 4 cycles with gnt_i tied high and rvalid_i arriving one cycle after grant.
REQ-025 When req_o=0, addr_o, wdata_o, we_o and be_o SHALL drive 0.

Reset
REQ-026 When rst_i=1 at any time, including mid-transfer, the block SHALL asynchronously force IDLE.
REQ-027 Under reset, req_o, we_o, busy_o, done_o and error_o SHALL be 0, addr_o=0, wdata_o=0, be_o=0, and the count, addresses and buffer SHALL be 0.
REQ-028 After reset release, the block SHALL ignore any response belonging to a transaction begun before reset.

Structure
REQ-029 user_pkg SHALL gain NumUserDomainManagers=1 and a manager index enum entry UserDma=0; the address map of the user subordinate port is unchanged.
REQ-030 The state enum SHALL be local to the module; no sub-module is used, and the OBI request/response struct typedefs come from the shared croc OBI typedefs.

Verification
REQ-031 Copy test: src=0x2000_0000, dst=0x1000_0100, len=3, gnt tied 1, rvalid one cycle later -> 3 reads then 3 writes, interleaved R,W,R,W,R,W; write addresses 0x1000_0100/104/108; done_o pulses once; total 12 cycles start-to-done.
REQ-032 Backpressure test: gnt_i held 0 for 5 cycles on the first write -> addr_o and wdata_o stable for all 5 cycles, req_o stays 1, and the copied data is correct.
REQ-033 Zero-length test: len=0 -> no req_o at all; done_o is seen 1 cycle after start and busy_o is high for exactly 1 cycle.
REQ-034 Error test: err_i=1 on the 2nd read of len=4 -> exactly one write is seen, error_o=1, done_o pulses, and the next start clears error_o.
REQ-035 Reset test: rst_i asserted while in WR_RSP -> all outputs go to 0 immediately, and a stray rvalid_i after release produces no state change.
REQ-036 Wrap/alignment test: src=0xFFFF_FFFC, len=2, src_addr_i bits[1:0]=2'b11 -> read addresses 0xFFFF_FFFC then 0x0000_0000.
